// File: rtl/cpu_irq_timer.sv
// cpu_irq_timer: configurable CPU-cycle / scanline IRQ counter for the mapper set.
// A byte-wide register port loads the latch, control and counter. A terminal tick
// sets a sticky pending flag that drives the active-low cartridge IRQ.
module cpu_irq_timer #(
    parameter int COUNTER_WIDTH     = 16,
    parameter int PRESCALE_PERIOD   = 341,
    parameter int PRESCALE_STEP     = 3,
    parameter int USE_SCANLINE_MODE = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     reg_we_i,
    input  logic [2:0]               reg_sel_i,
    input  logic [7:0]               reg_data_i,
    output logic                     irq_o,
    output logic                     irq_pending_o,
    output logic [COUNTER_WIDTH-1:0] counter_o
);

    localparam logic [9:0] PERIOD     = 10'(PRESCALE_PERIOD);
    localparam logic [9:0] STEP       = 10'(PRESCALE_STEP);
    localparam logic [9:0] RELOAD_ADD = 10'(PRESCALE_PERIOD - PRESCALE_STEP);
    localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [COUNTER_WIDTH-1:0] ONE      = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] LOW_MASK = COUNTER_WIDTH'(8'hFF);
    // Without the prescaler the mode bit is tied low, so the prescaler flop has
    // no fanout and drops out in synthesis.
    localparam bit SCAN_EN = (USE_SCANLINE_MODE != 0);

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] latch_q, latch_d;
    logic [9:0]               presc_q, presc_d, presc_tick;
    logic                     en_q, en_d;
    logic                     eaa_q, eaa_d;
    logic                     mode_q, mode_d;
    logic                     dir_q, dir_d;
    logic                     reload_q, reload_d;
    logic                     pend_q, pend_d;
    logic                     tick;
    logic                     terminal;
    logic                     clear_pend;

    // Tick generation: every enabled edge in cycle mode, prescaler underflow in scanline mode.
    always_comb begin
        tick       = 1'b0;
        presc_tick = presc_q;
        if (en_q) begin
            if (mode_q) begin
                if (presc_q > STEP) begin
                    presc_tick = presc_q - STEP;
                end else begin
                    presc_tick = presc_q + RELOAD_ADD;
                    tick       = 1'b1;
                end
            end else begin
                tick = 1'b1;
            end
        end
    end

    // Terminal is judged on the pre-edge count.
    assign terminal = tick && (dir_q ? (cnt_q == '0) : (cnt_q == ALL_ONES));

    // Next state: tick update first, register writes override counter/prescaler/enable.
    always_comb begin
        cnt_d      = cnt_q;
        latch_d    = latch_q;
        presc_d    = presc_tick;
        en_d       = en_q;
        eaa_d      = eaa_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        reload_d   = reload_q;
        clear_pend = 1'b0;

        if (tick) begin
            if (terminal) begin
                if (reload_q) cnt_d = latch_q;
                else          cnt_d = dir_q ? ALL_ONES : '0;
            end else begin
                cnt_d = dir_q ? (cnt_q - ONE) : (cnt_q + ONE);
            end
        end

        if (reg_we_i) begin
            case (reg_sel_i)
                3'd0: latch_d = (latch_q & ~LOW_MASK) | COUNTER_WIDTH'(reg_data_i);
                3'd1: latch_d = (latch_q & LOW_MASK) | COUNTER_WIDTH'({reg_data_i, 8'h00});
                3'd2: begin
                    en_d       = reg_data_i[0];
                    eaa_d      = reg_data_i[1];
                    mode_d     = SCAN_EN & reg_data_i[2];
                    dir_d      = reg_data_i[3];
                    reload_d   = reg_data_i[4];
                    clear_pend = 1'b1;
                    if (reg_data_i[0]) begin
                        cnt_d   = latch_q;
                        presc_d = PERIOD;
                    end
                end
                3'd3: begin
                    en_d       = eaa_q;
                    clear_pend = 1'b1;
                end
                3'd4: cnt_d = (cnt_q & ~LOW_MASK) | COUNTER_WIDTH'(reg_data_i);
                3'd5: cnt_d = (cnt_q & LOW_MASK) | COUNTER_WIDTH'({reg_data_i, 8'h00});
                default: ;
            endcase
        end

        // A terminal tick wins over a same-edge clear so no interrupt is lost.
        if (terminal)        pend_d = 1'b1;
        else if (clear_pend) pend_d = 1'b0;
        else                 pend_d = pend_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            latch_q  <= '0;
            presc_q  <= PERIOD;
            en_q     <= 1'b0;
            eaa_q    <= 1'b0;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
            reload_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            latch_q  <= latch_d;
            presc_q  <= presc_d;
            en_q     <= en_d;
            eaa_q    <= eaa_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            reload_q <= reload_d;
            pend_q   <= pend_d;
        end
    end

    assign irq_o         = ~pend_q;
    assign irq_pending_o = pend_q;
    assign counter_o     = cnt_q;

endmodule

// File: tb/tb_cpu_irq_timer.sv
// Bench for cpu_irq_timer: a 16-bit scanline-capable instance and an 8-bit
// cycle-only instance share one stimulus stream and are compared every edge
// against an integer reference model, plus directed boundary checks.
module tb_cpu_irq_timer;

    localparam int PERIOD = 341;
    localparam int STEP   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  sel;
    logic [7:0]  data;
    logic        irq_a, pend_a;
    logic [15:0] cnt_a;
    logic        irq_b, pend_b;
    logic [7:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    // Reference model state, index 0 = 16-bit scanline instance, 1 = 8-bit cycle-only.
    int m_w[2]    = '{16, 8};
    bit m_scan[2] = '{1'b1, 1'b0};
    int m_cnt[2], m_latch[2], m_presc[2];
    bit m_en[2], m_eaa[2], m_mode[2], m_dir[2], m_reload[2], m_pend[2];

    logic [2:0] r_sel;
    logic [7:0] r_data;
    int         first_edge;

    always #5 clk = ~clk;

    cpu_irq_timer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reg_we_i     (we),
        .reg_sel_i    (sel),
        .reg_data_i   (data),
        .irq_o        (irq_a),
        .irq_pending_o(pend_a),
        .counter_o    (cnt_a)
    );

    cpu_irq_timer #(.COUNTER_WIDTH(8), .USE_SCANLINE_MODE(0)) dut8 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reg_we_i     (we),
        .reg_sel_i    (sel),
        .reg_data_i   (data),
        .irq_o        (irq_b),
        .irq_pending_o(pend_b),
        .counter_o    (cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_latch[i] = 0; m_presc[i] = PERIOD;
            m_en[i] = 0; m_eaa[i] = 0; m_mode[i] = 0; m_dir[i] = 0;
            m_reload[i] = 0; m_pend[i] = 0;
        end
    endtask

    task automatic model_edge(input bit w, input logic [2:0] s, input logic [7:0] d);
        for (int i = 0; i < 2; i++) begin
            int maxv, cnt, latch;
            bit tick, term, clr;
            maxv = (1 << m_w[i]) - 1;
            cnt = m_cnt[i]; latch = m_latch[i];
            tick = 0; term = 0; clr = 0;
            if (m_en[i]) begin
                if (m_mode[i]) begin
                    if (m_presc[i] > STEP) m_presc[i] = m_presc[i] - STEP;
                    else begin m_presc[i] = m_presc[i] + PERIOD - STEP; tick = 1; end
                end else tick = 1;
            end
            if (tick) begin
                if (m_dir[i]) begin
                    if (m_cnt[i] == 0) begin term = 1; cnt = m_reload[i] ? m_latch[i] : maxv; end
                    else cnt = m_cnt[i] - 1;
                end else begin
                    if (m_cnt[i] == maxv) begin term = 1; cnt = m_reload[i] ? m_latch[i] : 0; end
                    else cnt = m_cnt[i] + 1;
                end
            end
            if (w) begin
                case (s)
                    3'd0: latch = (m_latch[i] & ~255) | int'(d);
                    3'd1: latch = (m_latch[i] & 255) | ((int'(d) << 8) & maxv);
                    3'd2: begin
                        m_en[i] = d[0]; m_eaa[i] = d[1]; m_mode[i] = m_scan[i] && d[2];
                        m_dir[i] = d[3]; m_reload[i] = d[4]; clr = 1;
                        if (d[0]) begin cnt = m_latch[i]; m_presc[i] = PERIOD; end
                    end
                    3'd3: begin m_en[i] = m_eaa[i]; clr = 1; end
                    3'd4: cnt = (m_cnt[i] & ~255) | int'(d);
                    3'd5: cnt = ((m_cnt[i] & 255) | (int'(d) << 8)) & maxv;
                    default: ;
                endcase
            end
            if (term) m_pend[i] = 1;
            else if (clr) m_pend[i] = 0;
            m_cnt[i] = cnt; m_latch[i] = latch;
        end
    endtask

    task automatic check_all();
        chk("irq16",   32'(irq_a),  32'(!m_pend[0]));
        chk("pend16",  32'(pend_a), 32'(m_pend[0]));
        chk("count16", 32'(cnt_a),  32'(m_cnt[0]));
        chk("irq8",    32'(irq_b),  32'(!m_pend[1]));
        chk("pend8",   32'(pend_b), 32'(m_pend[1]));
        chk("count8",  32'(cnt_b),  32'(m_cnt[1]));
    endtask

    task automatic step(input bit w, input logic [2:0] s, input logic [7:0] d);
        we = w; sel = s; data = d;
        @(posedge clk);
        model_edge(w, s, d);
        #1;
        check_all();
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; sel = '0; data = '0;
        model_reset();
        #12;
        check_all();
        chk("reset_irq", 32'(irq_a), 32'd1);
        chk("reset_cnt", 32'(cnt_a), 32'd0);
        rst_n = 1'b1;

        // Cycle mode, up, reload from 0xFFFD: IRQ after the 3rd edge.
        step(1, 3'd0, 8'hFD); step(1, 3'd1, 8'hFF); step(1, 3'd2, 8'h11);
        step(0, 3'd0, 8'h00); step(0, 3'd0, 8'h00);
        chk("up_no_irq_yet", 32'(irq_a), 32'd1);
        step(0, 3'd0, 8'h00);
        chk("up_irq_edge3", 32'(irq_a), 32'd0);
        chk("up_reload_cnt", 32'(cnt_a), 32'hFFFD);
        chk("w8_up_reload_cnt", 32'(cnt_b), 32'hFD);
        step(1, 3'd3, 8'h00);
        chk("ack_irq_high", 32'(irq_a), 32'd1);
        step(0, 3'd0, 8'h00);
        chk("ack_disabled_hold", 32'(cnt_a), 32'hFFFE);

        // Cycle mode, down, wrap from 2.
        step(1, 3'd0, 8'h02); step(1, 3'd1, 8'h00); step(1, 3'd2, 8'h09);
        step(0, 3'd0, 8'h00); step(0, 3'd0, 8'h00); step(0, 3'd0, 8'h00);
        chk("down_pend_edge3", 32'(pend_a), 32'd1);
        chk("down_wrap_cnt", 32'(cnt_a), 32'hFFFF);
        chk("w8_down_wrap_cnt", 32'(cnt_b), 32'hFF);
        step(0, 3'd0, 8'h00);
        chk("down_after_wrap", 32'(cnt_a), 32'hFFFE);
        step(1, 3'd3, 8'h00);

        // Scanline mode: 341 drops by 3 per edge, first reaches <=3 (value 2) on edge 114.
        step(1, 3'd0, 8'hFF); step(1, 3'd1, 8'hFF); step(1, 3'd2, 8'h17);
        first_edge = 0;
        for (int n = 1; n <= 200; n++) begin
            step(0, 3'd0, 8'h00);
            if (pend_a) begin first_edge = n; break; end
        end
        chk("scan_tick1_edge", 32'(first_edge), 32'd114);
        // Prescaler is now 2+338=340; 340-3*113=1 is first reached on the 114th edge.
        step(1, 3'd0, 8'hFE);
        step(1, 3'd3, 8'h00);
        chk("scan_ack_clear", 32'(pend_a), 32'd0);
        first_edge = 0;
        for (int n = 3; n <= 250; n++) begin
            step(0, 3'd0, 8'h00);
            if (pend_a) begin first_edge = n; break; end
        end
        chk("scan_tick2_edge", 32'(first_edge), 32'd114);
        chk("scan_tick2_reload", 32'(cnt_a), 32'hFFFE);
        step(1, 3'd2, 8'h00);

        // Ack and control write colliding with a terminal tick.
        step(1, 3'd0, 8'hFE); step(1, 3'd1, 8'hFF); step(1, 3'd2, 8'h11);
        step(0, 3'd0, 8'h00); step(0, 3'd0, 8'h00);
        chk("col_setup_pend", 32'(pend_a), 32'd1);
        step(0, 3'd0, 8'h00);
        step(1, 3'd3, 8'h00);
        chk("ack_collide_irq", 32'(irq_a), 32'd0);
        chk("w8_ack_collide_irq", 32'(irq_b), 32'd0);
        step(1, 3'd2, 8'h11);
        chk("ctl_clear", 32'(pend_a), 32'd0);
        step(0, 3'd0, 8'h00);
        step(1, 3'd2, 8'h11);
        chk("ctl_collide_pend", 32'(pend_a), 32'd1);
        chk("ctl_collide_cnt", 32'(cnt_a), 32'hFFFE);

        // Width-8 instance ignores high-byte writes; 0xFE up-count fires on the 2nd edge.
        step(1, 3'd2, 8'h00);
        step(1, 3'd4, 8'h12); step(1, 3'd5, 8'hAB);
        chk("cnt_hi_write16", 32'(cnt_a), 32'hAB12);
        chk("cnt_hi_write8", 32'(cnt_b), 32'h12);
        step(1, 3'd0, 8'hFE); step(1, 3'd1, 8'h33); step(1, 3'd2, 8'h01);
        chk("w8_latch_hi_ignored", 32'(cnt_b), 32'hFE);
        step(0, 3'd0, 8'h00); step(0, 3'd0, 8'h00);
        chk("w8_irq_edge2", 32'(irq_b), 32'd0);

        // Asynchronous reset between edges while pending.
        step(1, 3'd0, 8'hFE); step(1, 3'd1, 8'hFF); step(1, 3'd2, 8'h11);
        step(0, 3'd0, 8'h00); step(0, 3'd0, 8'h00);
        chk("rst_setup_pend", 32'(pend_a), 32'd1);
        #2 rst_n = 1'b0;
        #2;
        chk("async_rst_irq", 32'(irq_a), 32'd1);
        chk("async_rst_cnt", 32'(cnt_a), 32'd0);
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        step(0, 3'd0, 8'h00);
        chk("rst_no_tick", 32'(cnt_a), 32'd0);

        // Randomized register traffic against the model.
        for (int k = 0; k < 600; k++) begin
            r_sel  = 3'($urandom_range(0, 7));
            r_data = 8'($urandom);
            if (r_sel == 3'd2) r_data[0] = ($urandom_range(0, 3) != 0);
            if ((r_sel == 3'd1 || r_sel == 3'd5) && $urandom_range(0, 1) == 1) r_data = 8'hFF;
            if ($urandom_range(0, 3) == 0) step(1, r_sel, r_data);
            else                           step(0, 3'd0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
